// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: receiver FSM encodings and default frame geometry.
// Also imported by the transmitter-side wrapper.
package serial_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_e;

endpackage

// File: rtl/rx_bit_counter.sv
// Bit counter for the serial receiver: sync clear, enable, and a terminal flag on the last bit.
// It wraps back to zero when it counts past the last bit, so a completed frame leaves it ready for the next one.
module rx_bit_counter
  import serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             terminal
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_r;

  assign cnt      = cnt_r;
  assign terminal = (cnt_r == LAST_CNT);

  // Bit position within the current frame; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      if (terminal) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-in/parallel-out receiver: rebuilds LSB-first words and presents them on a held
// output register with a valid/ready handshake and a sticky overrun flag.
module serial_word_receiver
  import serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_en,
  input  logic             start,
  input  logic             ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] word_out,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);

  rx_state_e        state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] word_r;
  logic             valid_r;
  logic             overrun_r;

  logic             recv_bit_s;
  logic             complete_s;
  logic             terminal_s;
  logic [CNT_W-1:0] cnt_s;
  logic [WIDTH-1:0] shift_next_s;

  assign recv_bit_s   = (state_r == ST_RECV) && bit_en;
  assign complete_s   = recv_bit_s && terminal_s;
  assign shift_next_s = {serial_in, shreg_r[WIDTH-1:1]};

  rx_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .clr      (start),
    .en       (recv_bit_s),
    .cnt      (cnt_s),
    .terminal (terminal_s)
  );

  // Frame FSM and shift register; a start always (re)opens a frame, even on the completing bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      shreg_r <= {WIDTH{1'b0}};
    end else if (start) begin
      state_r <= ST_RECV;
      shreg_r <= {WIDTH{1'b0}};
    end else if (recv_bit_s) begin
      shreg_r <= shift_next_s;
      state_r <= terminal_s ? ST_IDLE : ST_RECV;
    end else begin
      state_r <= state_r;
      shreg_r <= shreg_r;
    end
  end

  // Output word register: a word completing against an unconsumed, unaccepted word is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_r    <= {WIDTH{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (complete_s && (!valid_r || ready)) begin
        word_r  <= shift_next_s;
        valid_r <= 1'b1;
      end else if (valid_r && ready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end

      if (complete_s && valid_r && !ready) begin
        overrun_r <= 1'b1;
      end else if (clr_ovr) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign word_out = word_r;
  assign valid    = valid_r;
  assign busy     = (state_r == ST_RECV);
  assign overrun  = overrun_r;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Scoreboard bench for serial_word_receiver: stimulus pushes expected words, a monitor
// pops and compares them whenever the consumer accepts a word (valid & ready).
module tb_serial_word_receiver;

  logic       clk;
  logic       reset;
  logic       serial_in;
  logic       bit_en;
  logic       start;
  logic       ready;
  logic       clr_ovr;
  logic [7:0] word_out;
  logic       valid;
  logic       busy;
  logic       overrun;

  int         checks;
  int         errors;
  int         pops;
  logic [7:0] exp_q[$];

  serial_word_receiver #(.WIDTH(8), .CNT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .serial_in (serial_in),
    .bit_en    (bit_en),
    .start     (start),
    .ready     (ready),
    .clr_ovr   (clr_ovr),
    .word_out  (word_out),
    .valid     (valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every accepted word must be the oldest expected word.
  always @(negedge clk) begin
    if (!reset && valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL accepted_word: got 0x%02h, expected no word", word_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        pops++;
        if (word_out !== e) begin
          errors++;
          $display("FAIL accepted_word: got 0x%02h, expected 0x%02h", word_out, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Send nbits LSB-first; gapped inserts 1..3 idle cycles before each bit after the first.
  task automatic send_bits(input logic [7:0] w, input int nbits, input bit gapped,
                           input bit start_last, input bit ready_last);
    for (int i = 0; i < nbits; i++) begin
      if (gapped && i > 0) repeat ((i % 3) + 1) tick();
      serial_in = w[i];
      bit_en    = 1'b1;
      if (i == nbits - 1) begin
        start = start_last;
        if (ready_last) ready = 1'b1;
      end
      tick();
      bit_en = 1'b0;
      start  = 1'b0;
      if (ready_last && i == nbits - 1) ready = 1'b0;
    end
  endtask

  task automatic drain_one();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; pops = 0;
    reset = 1'b1; serial_in = 1'b0; bit_en = 1'b0; start = 1'b0;
    ready = 1'b0; clr_ovr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset_word", word_out, 8'h00);
    check("reset_valid", {7'd0, valid}, 8'h00);
    check("reset_busy", {7'd0, busy}, 8'h00);
    check("reset_overrun", {7'd0, overrun}, 8'h00);

    // bit_en in IDLE must be ignored
    send_bits(8'hFF, 3, 1'b0, 1'b0, 1'b0);
    check("idle_busy", {7'd0, busy}, 8'h00);

    // 0xA5 basic frame
    pulse_start();
    check("busy_after_start", {7'd0, busy}, 8'h01);
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 7, 1'b0, 1'b0, 1'b0);
    check("valid_before_last", {7'd0, valid}, 8'h00);
    send_bits(8'h01, 1, 1'b0, 1'b0, 1'b0);
    check("a5_word", word_out, 8'hA5);
    check("a5_valid", {7'd0, valid}, 8'h01);
    check("a5_busy", {7'd0, busy}, 8'h00);
    drain_one();
    check("a5_valid_cleared", {7'd0, valid}, 8'h00);

    // 0x3C held, 0xFF dropped -> overrun
    pulse_start();
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    pulse_start();
    send_bits(8'hFF, 8, 1'b0, 1'b0, 1'b0);
    check("ovr_word", word_out, 8'h3C);
    check("ovr_flag", {7'd0, overrun}, 8'h01);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("ovr_cleared", {7'd0, overrun}, 8'h00);
    check("ovr_word_kept", word_out, 8'h3C);

    // 0x81 completes on the edge where 0x3C is accepted
    pulse_start();
    exp_q.push_back(8'h81);
    send_bits(8'h81, 8, 1'b0, 1'b0, 1'b1);
    check("b2b_word", word_out, 8'h81);
    check("b2b_valid", {7'd0, valid}, 8'h01);
    check("b2b_overrun", {7'd0, overrun}, 8'h00);
    drain_one();

    // restart mid-frame
    pulse_start();
    send_bits(8'hFF, 4, 1'b0, 1'b0, 1'b0);
    pulse_start();
    check("restart_busy", {7'd0, busy}, 8'h01);
    exp_q.push_back(8'h12);
    send_bits(8'h12, 8, 1'b0, 1'b0, 1'b0);
    check("restart_word", word_out, 8'h12);
    drain_one();

    // gapped 0x5A with start on its last bit, then 0x07
    ready = 1'b1;
    pulse_start();
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h07);
    send_bits(8'h5A, 8, 1'b1, 1'b1, 1'b0);
    check("gap_word", word_out, 8'h5A);
    check("gap_busy_restart", {7'd0, busy}, 8'h01);
    send_bits(8'h07, 8, 1'b0, 1'b0, 1'b0);
    check("chain_word", word_out, 8'h07);
    check("chain_valid", {7'd0, valid}, 8'h01);
    tick();
    ready = 1'b0;

    // reset mid-frame with valid and overrun set
    pulse_start();
    exp_q.push_back(8'h99);
    send_bits(8'h99, 8, 1'b0, 1'b0, 1'b0);
    pulse_start();
    send_bits(8'h11, 8, 1'b0, 1'b0, 1'b0);
    pulse_start();
    send_bits(8'hFF, 5, 1'b0, 1'b0, 1'b0);
    check("pre_reset_overrun", {7'd0, overrun}, 8'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("mid_reset_word", word_out, 8'h00);
    check("mid_reset_valid", {7'd0, valid}, 8'h00);
    check("mid_reset_busy", {7'd0, busy}, 8'h00);
    check("mid_reset_overrun", {7'd0, overrun}, 8'h00);
    pulse_start();
    exp_q.push_back(8'hC3);
    send_bits(8'hC3, 8, 1'b0, 1'b0, 1'b0);
    check("fresh_word", word_out, 8'hC3);
    drain_one();
    tick();

    check("queue_empty", 8'(exp_q.size()), 8'h00);
    check("words_accepted", 8'(pops), 8'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Serial-in/parallel-out receiver; the far end of the 8-bit right-shift transmitter link, whose Q[0] shifts out LSB first.
- Rebuilds WIDTH-bit words from a serial bit stream gated by a bit-enable strobe and framed by a start pulse.
- Presents each completed word on a held output register with a valid/ready handshake.
- Sits between the shifter/serial link and downstream consumers (LED display, register file).

Parameters:
- WIDTH, 8, bits per frame/word (≥2)
- CNT_W, 3, bit-counter width; must satisfy 2^CNT_W ≥ WIDTH

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on the clk edge where high
- serial_in  input  1  serial data bit, LSB first
- bit_en  input  1  qualifies serial_in for one clk cycle
- start  input  1  one-cycle frame start pulse
- ready  input  1  consumer accepts word_out when valid&ready
- clr_ovr  input  1  clears sticky overrun
- word_out  output  WIDTH  last completed word
- valid  output  1  word_out holds an unconsumed word
- busy  output  1  frame in progress (state RECV)
- overrun  output  1  sticky: a completed word was dropped

Behaviour:
- Reset: state=IDLE, shift reg=0, bit_cnt=0, word_out=0, valid=0, busy=0, overrun=0. Reset overrides every other input, including mid-frame; the partial word is discarded.
- FSM states: IDLE, RECV. busy = (state==RECV).
- IDLE:
  - bit_en is ignored.
  - start=1 -> RECV with bit_cnt=0 and shift reg=0.
- RECV, on bit_en=1:
  - shift reg <= {serial_in, shreg[WIDTH-1:1]} (right shift, new bit enters MSB, so the first bit lands in bit 0 after WIDTH shifts).
  - bit_cnt <= bit_cnt+1.
- Frame completion: bit_en=1 while bit_cnt==WIDTH-1.
  - Completed word = {serial_in, shreg[WIDTH-1:1]}.
  - Next state IDLE; bit_cnt <= 0.
  - Output latency: word_out/valid update on the same edge that samples the last bit, so they are visible the following cycle.
- Output register and handshake:
  - valid&ready at an edge clears valid, unless a new word completes on that edge.
  - On completion with valid=0, or with valid=1 and ready=1: load word_out, valid <= 1, no overrun.
  - On completion with valid=1 and ready=0: drop the new word, keep word_out, overrun <= 1.
  - word_out is held stable while valid=1 and ready=0.
- start during RECV: restart the frame (bit_cnt=0, shreg=0). The partial word is lost silently; no flag.
- start together with the completing bit_en: completion is processed (word delivered), then a new frame begins. Next state RECV, bit_cnt=0.
- bit_en=0 cycles in RECV: hold all state; there is no timeout.
- overrun: sticky until reset or clr_ovr=1. If clr_ovr and a new overrun coincide, overrun stays 1 (set wins).
- valid does not depend combinationally on ready; all outputs are registered.

Decomposition:
- Shared package serial_pkg holds:
  - state encodings: ST_IDLE=1'b0, ST_RECV=1'b1
  - default WIDTH=8, CNT_W=3
- The same package is reused by the transmitter-side wrapper.
- One natural sub-module: rx_bit_counter.
  - Function: CNT_W-bit counter with sync clear, enable, and terminal flag (cnt==WIDTH-1).
  - Instantiated once.
- Shift register, output register and FSM stay in the top module.

Test Plan:
- Reset, then start, then 8 bit_en cycles with bits 1,0,1,0,0,1,0,1 -> word_out=0xA5, valid=1 on the cycle after the 8th bit, busy falls to 0 on that same cycle; ready=1 one cycle later -> valid=0.
- Receive 0x3C with ready=0, then 0xFF with ready=0 -> word_out stays 0x3C, overrun=1; clr_ovr pulse -> overrun=0, word_out still 0x3C.
- Receive 0x3C, hold ready=1 at the edge completing 0x81 -> word_out=0x81, valid stays 1, overrun=0.
- Send 4 bits of 0xFF, then start, then 8 bits of 0x12 -> word_out=0x12; only one valid assertion.
- Insert bit_en=0 gaps of 1–3 cycles between the bits of 0x5A -> word_out=0x5A; a start coinciding with the last bit of 0x5A is followed by 8 bits of 0x07 -> 0x5A, then 0x07.
- Assert reset after 5 bits -> all outputs 0 on the next cycle; a fresh frame of 0xC3 is then received correctly.
